// File: rtl/lsu_pkg.sv
// Shared LSU types: uop fields, size codes, fault codes, FSM states.
// Imported by lsu_align and lsu_mem_ctrl.
package lsu_pkg;

  localparam int UOP_ST  = 3;
  localparam int UOP_UNS = 2;

  typedef enum logic [1:0] {
    SZ_D = 2'b00,
    SZ_B = 2'b01,
    SZ_H = 2'b10,
    SZ_W = 2'b11
  } size_e;

  localparam logic [1:0] FLT_OK  = 2'b00;
  localparam logic [1:0] FLT_MIS = 2'b01;
  localparam logic [1:0] FLT_TMO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store replication,
// load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int BW   = XLEN / 8,
  localparam int OW   = $clog2(BW)
) (
  input  size_e            size_in,
  input  logic             uns_in,
  input  logic [OW-1:0]    off_in,
  input  logic [XLEN-1:0]  sdata_in,
  input  logic [XLEN-1:0]  rdata_in,
  output logic [BW-1:0]    be_out,
  output logic [XLEN-1:0]  wdata_out,
  output logic [XLEN-1:0]  ldata_out
);

  logic [BW-1:0]   mask;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] keep;
  logic            sb;

  always_comb begin
    mask      = '1;
    wdata_out = sdata_in;
    keep      = '1;
    sb        = 1'b0;
    sh        = rdata_in >> {off_in, 3'b000};
    unique case (size_in)
      SZ_B: begin
        mask      = BW'(1);
        wdata_out = {BW{sdata_in[7:0]}};
        keep      = XLEN'(8'hFF);
        sb        = sh[7];
      end
      SZ_H: begin
        mask      = BW'(3);
        wdata_out = {(BW/2){sdata_in[15:0]}};
        keep      = XLEN'(16'hFFFF);
        sb        = sh[15];
      end
      SZ_W: begin
        mask      = BW'(4'hF);
        wdata_out = {(XLEN/32){sdata_in[31:0]}};
        keep      = XLEN'(32'hFFFF_FFFF);
        sb        = sh[31];
      end
      SZ_D: begin
        mask      = '1;
        wdata_out = sdata_in;
        keep      = '1;
        sb        = 1'b0;
      end
      default: ;
    endcase
    be_out    = mask << off_in;
    ldata_out = (sh & keep)
              | ((~uns_in & sb) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU memory controller: IDLE/REQ/DONE request FSM.
// Define LSU_TIMEOUT_EN to abort REQ after MAX_WAIT cycles.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clock_in,
  input  logic              reset_in,
  input  logic              lsu_valid_in,
  output logic              lsu_ready_out,
  input  logic [3:0]        lsu_uop_in,
  input  logic [XLEN-1:0]   lsu_a_data_in,
  input  logic [XLEN-1:0]   lsu_b_data_in,
  input  logic [XLEN-1:0]   lsu_c_data_in,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [XLEN/8-1:0] mem_be_out,
  output logic [XLEN-1:0]   mem_addr_out,
  output logic [XLEN-1:0]   mem_wdata_out,
  input  logic [XLEN-1:0]   mem_rdata_in,
  input  logic              mem_ack_in,
  output logic              lsu_done_out,
  output logic [XLEN-1:0]   lsu_result_out,
  output logic [1:0]        lsu_fault_out
);

  localparam int BW = XLEN / 8;
  localparam int OW = $clog2(BW);

  state_e          state_q, state_d;
  size_e           size_q, size_d, size_in;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [1:0]      fault_q, fault_d;
  logic            we_q, we_d, uns_q, uns_d;
  logic [XLEN-1:0] ea;
  logic            misal, timeout, req;
  logic [BW-1:0]   be;
  logic [XLEN-1:0] wdata, ldata;

  assign ea  = lsu_b_data_in + lsu_c_data_in;
  assign req = (state_q == S_REQ);

  // Doubleword code only exists on 64-bit; 32-bit falls back to word
  always_comb begin
    size_in = size_e'(lsu_uop_in[1:0]);
    if (XLEN == 32 && size_in == SZ_D)
      size_in = SZ_W;
    unique case (size_in)
      SZ_B:    misal = 1'b0;
      SZ_H:    misal = ea[0];
      SZ_W:    misal = |ea[1:0];
      default: misal = |ea[OW-1:0];
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign cnt_d   = req ? cnt_q + CW'(1) : '0;
  assign timeout = req && (cnt_q == CW'(MAX_WAIT - 1));

  always_ff @(posedge clock_in) begin
    if (reset_in) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    we_d     = we_q;
    uns_d    = uns_q;
    result_d = result_q;
    fault_d  = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (lsu_valid_in) begin
          size_d   = size_in;
          addr_d   = ea;
          sdata_d  = lsu_a_data_in;
          we_d     = lsu_uop_in[UOP_ST];
          uns_d    = lsu_uop_in[UOP_UNS];
          result_d = '0;
          fault_d  = misal ? FLT_MIS : FLT_OK;
          state_d  = misal ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack_in) begin
          result_d = we_q ? '0 : ldata;
          fault_d  = FLT_OK;
          state_d  = S_DONE;
        end else if (timeout) begin
          result_d = '0;
          fault_d  = FLT_TMO;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      size_q   <= SZ_B;
      addr_q   <= '0;
      sdata_q  <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      result_q <= '0;
      fault_q  <= FLT_OK;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      we_q     <= we_d;
      uns_q    <= uns_d;
      result_q <= result_d;
      fault_q  <= fault_d;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_in   (size_q),
    .uns_in    (uns_q),
    .off_in    (addr_q[OW-1:0]),
    .sdata_in  (sdata_q),
    .rdata_in  (mem_rdata_in),
    .be_out    (be),
    .wdata_out (wdata),
    .ldata_out (ldata)
  );

  assign lsu_ready_out  = (state_q == S_IDLE);
  assign lsu_done_out   = (state_q == S_DONE);
  assign lsu_result_out = result_q;
  assign lsu_fault_out  = fault_q;
  assign mem_req_out    = req;
  assign mem_we_out     = req & we_q;
  assign mem_be_out     = req ? be : '0;
  assign mem_wdata_out  = req ? wdata : '0;
  assign mem_addr_out   = req ? {addr_q[XLEN-1:OW], {OW{1'b0}}} : '0;

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 Parameter XLEN, default 32, data/address width; SHALL be 32 or 64.
REQ-002 Parameter MAX_WAIT, default 15, cycles allowed for mem_ack_in before timeout (used only with LSU_TIMEOUT_EN).
REQ-003 clock_in  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset_in  input  1  synchronous, active-high reset.
REQ-005 lsu_valid_in  input  1  EX issues an operation.
REQ-006 lsu_ready_out  output  1  block accepts an operation this cycle.
REQ-007 lsu_uop_in  input  4  bit3 store, bit2 unsigned, [1:0] 01 byte, 10 half, 11 word, 00 doubleword (XLEN=64 only).
REQ-008 lsu_a_data_in / lsu_b_data_in / lsu_c_data_in  input  XLEN each  store data / base / offset.
REQ-009 mem_req_out  output  1; mem_we_out  output  1; mem_be_out  output  XLEN/8; mem_addr_out  output  XLEN; mem_wdata_out  output  XLEN.
REQ-010 mem_rdata_in  input  XLEN; mem_ack_in  input  1  memory completes the request.
REQ-011 lsu_done_out  output  1  one-cycle completion pulse; lsu_result_out  output  XLEN  load result; lsu_fault_out  output  2  00 ok, 01 misaligned, 10 timeout.

Function
REQ-012 Effective address SHALL be b+c modulo 2^XLEN, computed and registered at acceptance.
REQ-013 Acceptance SHALL occur on a cycle with lsu_valid_in and lsu_ready_out both high; ready SHALL be high only in IDLE.
REQ-014 FSM states: IDLE, REQ, DONE; IDLE->REQ on aligned acceptance, IDLE->DONE on misaligned acceptance, REQ->DONE on mem_ack_in (or timeout), DONE->IDLE unconditionally.
REQ-015 In REQ, mem_req_out SHALL be held high with address, we, be, wdata stable until the ack cycle inclusive; first request cycle is acceptance+1.
REQ-016 mem_addr_out SHALL be the effective address with low log2(XLEN/8) bits cleared; mem_be_out SHALL enable only lanes covered by size at the byte offset.
REQ-017 Store data SHALL be replicated/shifted so the low bytes of lsu_a_data_in land in the enabled lanes; mem_we_out = uop bit3.
REQ-018 Load data SHALL be captured on the ack cycle, shifted by the byte offset, then sign- or zero-extended per bit2; word on XLEN=64 extends from bit 31.
REQ-019 Misaligned (half with offset bit0 set, word with offset[1:0]!=0, doubleword with offset!=0) SHALL issue no memory request; fault=01, result 0.
REQ-020 lsu_done_out SHALL be high exactly one cycle (DONE); result and fault valid in that cycle and held until next acceptance.
REQ-021 Store completion SHALL drive lsu_result_out to 0.
REQ-022 mem_ack_in outside REQ SHALL be ignored.
REQ-023 Uop 00 on XLEN=32 SHALL be treated as word.
REQ-024 Minimum latency: accept cycle N, ack at N+1, done at N+2.

Reset
REQ-025 reset_in SHALL force IDLE and all outputs to 0 except lsu_ready_out=1, on the next edge.
REQ-026 reset_in during REQ SHALL drop mem_req_out the following cycle with no done pulse; a later ack SHALL be ignored.
REQ-027 reset_in SHALL take precedence over simultaneous valid or ack.

Configuration
REQ-028 With LSU_TIMEOUT_EN defined, a wait counter SHALL count REQ cycles; reaching MAX_WAIT without ack SHALL go to DONE with fault=10, result 0, request dropped.
REQ-029 Without LSU_TIMEOUT_EN, no counter SHALL exist and REQ SHALL wait indefinitely; fault code 10 never produced.

Structure
REQ-030 Package lsu_pkg SHALL hold uop field positions, size codes, fault codes and FSM state encodings.
REQ-031 Combinational sub-module lsu_align SHALL implement byte-enable generation, store lane shift and load extract/extension.

Verification
REQ-032 LW b=0x100 c=4, ack one cycle later, rdata 0xDEADBEEF -> addr 0x104, be 1111, done at N+2, result 0xDEADBEEF, fault 00.
REQ-033 LB b=0x103 c=0, rdata 0x80112233 -> be 1000, result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-034 SH a=0x0000ABCD addr 0x202 -> be 1100, wdata[31:16]=0xABCD, we=1, result 0.
REQ-035 LW addr 0x101 -> no mem_req_out, done at N+1, fault 01, result 0.
REQ-036 LSU_TIMEOUT_EN, MAX_WAIT=15, ack never -> req high 15 cycles, done with fault 10; without macro req stays high.
REQ-037 reset_in asserted mid-REQ then ack -> mem_req_out 0 next cycle, no done pulse, ready 1.
